// File: rtl/layer_mixer.sv
// N-layer priority compositor with per-layer colour keys; config commits at frame start.
// Latency 2 cycles, one pixel per clock, never stalls (no backpressure).
module layer_mixer #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb,
  input  logic                              hs_in,
  input  logic                              vs_in,
  input  logic                              blank_in,
  input  logic                              cfg_we,
  input  logic [3:0]                        cfg_addr,
  input  logic [31:0]                       cfg_data,
  output logic [3*COLOR_W-1:0]              rgb_out,
  output logic                              hs_out,
  output logic                              vs_out,
  output logic                              blank_out,
  output logic                              frame_drawn,
  output logic                              cfg_pending
);
  localparam int PIX_W = 3 * COLOR_W;
  localparam int IDX_W = $clog2(NUM_LAYERS);

  logic [NUM_LAYERS-1:0] en_sh_q, en_q;
  logic [PIX_W-1:0]      bg_sh_q, bg_q;
  logic [IDX_W-1:0]      prio_sh_q [NUM_LAYERS];
  logic [IDX_W-1:0]      prio_q    [NUM_LAYERS];
  logic [PIX_W-1:0]      key_sh_q  [NUM_LAYERS];
  logic [PIX_W-1:0]      key_q     [NUM_LAYERS];
  logic                  vs_prev_q, commit_q, pending_q;
  logic                  wr_ok;

  logic                        unused_cfg;
  assign unused_cfg = ^cfg_data;
  assign wr_ok = cfg_we && (cfg_addr < 4'(3 + NUM_LAYERS));

  // Shadow registers take CPU writes; active ones reload the cycle after vs_in rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_sh_q   <= '1;
      en_q      <= '1;
      bg_sh_q   <= '0;
      bg_q      <= '0;
      for (int s = 0; s < NUM_LAYERS; s++) begin
        prio_sh_q[s] <= IDX_W'(s);
        prio_q[s]    <= IDX_W'(s);
        key_sh_q[s]  <= '0;
        key_q[s]     <= '0;
      end
      vs_prev_q <= 1'b0;
      commit_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      vs_prev_q <= vs_in;
      commit_q  <= vs_in & ~vs_prev_q;
      if (commit_q) begin
        en_q   <= en_sh_q;
        bg_q   <= bg_sh_q;
        prio_q <= prio_sh_q;
        key_q  <= key_sh_q;
      end
      if (wr_ok) begin
        case (cfg_addr)
          4'd0: en_sh_q <= cfg_data[NUM_LAYERS-1:0];
          4'd1: bg_sh_q <= cfg_data[PIX_W-1:0];
          4'd2: for (int s = 0; s < NUM_LAYERS; s++) prio_sh_q[s] <= cfg_data[s*4 +: IDX_W];
          default: begin
            for (int i = 0; i < NUM_LAYERS; i++)
              if (cfg_addr == 4'(3 + i)) key_sh_q[i] <= cfg_data[PIX_W-1:0];
          end
        endcase
      end
      // A write in the commit cycle keeps pending set for the next frame.
      if (wr_ok)         pending_q <= 1'b1;
      else if (commit_q) pending_q <= 1'b0;
    end
  end

  logic [NUM_LAYERS-1:0]       vis_d, vis_s1_q;
  logic [NUM_LAYERS*PIX_W-1:0] pix_s1_q;
  logic [IDX_W-1:0]            prio_s1_q [NUM_LAYERS];
  logic [PIX_W-1:0]            bg_s1_q;
  logic                        hs_s1_q, vs_s1_q, blank_s1_q;

  always_comb begin
    vis_d = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      vis_d[i] = en_q[i] && (layer_rgb[i*PIX_W +: PIX_W] != key_q[i]);
  end

  // Stage 1 carries the active priority/background along so a mid-pipeline commit cannot split a pixel's config.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vis_s1_q   <= '0;
      pix_s1_q   <= '0;
      bg_s1_q    <= '0;
      for (int s = 0; s < NUM_LAYERS; s++) prio_s1_q[s] <= '0;
      hs_s1_q    <= 1'b0;
      vs_s1_q    <= 1'b0;
      blank_s1_q <= 1'b0;
    end else begin
      vis_s1_q   <= vis_d;
      pix_s1_q   <= layer_rgb;
      bg_s1_q    <= bg_q;
      prio_s1_q  <= prio_q;
      hs_s1_q    <= hs_in;
      vs_s1_q    <= vs_in;
      blank_s1_q <= blank_in;
    end
  end

  logic [PIX_W-1:0] rgb_d;
  logic             found;

  always_comb begin
    rgb_d = bg_s1_q;
    found = 1'b0;
    for (int s = 0; s < NUM_LAYERS; s++)
      for (int l = 0; l < NUM_LAYERS; l++)
        if (!found && prio_s1_q[s] == IDX_W'(l) && vis_s1_q[l]) begin
          rgb_d = pix_s1_q[l*PIX_W +: PIX_W];
          found = 1'b1;
        end
    if (blank_s1_q) rgb_d = '0;
  end

  logic [PIX_W-1:0] rgb_q;
  logic             hs_q, vs_q, blank_q, fd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q   <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      blank_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      hs_q    <= hs_s1_q;
      vs_q    <= vs_s1_q;
      blank_q <= blank_s1_q;
      fd_q    <= vs_s1_q & ~vs_q;
    end
  end

  assign rgb_out     = rgb_q;
  assign hs_out      = hs_q;
  assign vs_out      = vs_q;
  assign blank_out   = blank_q;
  assign frame_drawn = fd_q;
  assign cfg_pending = pending_q;
endmodule

// File: tb/tb_layer_mixer.sv
// Randomised and directed checks of layer_mixer against a per-pixel behavioural model.
module tb_layer_mixer;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int PW = 3 * CW;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N*PW-1:0] layer_rgb;
  logic            hs_in, vs_in, blank_in, cfg_we;
  logic [3:0]      cfg_addr;
  logic [31:0]     cfg_data;
  logic [PW-1:0]   rgb_out;
  logic            hs_out, vs_out, blank_out, frame_drawn, cfg_pending;

  always #5 clk = ~clk;

  layer_mixer #(.NUM_LAYERS(N), .COLOR_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .layer_rgb(layer_rgb),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .rgb_out(rgb_out), .hs_out(hs_out), .vs_out(vs_out), .blank_out(blank_out),
    .frame_drawn(frame_drawn), .cfg_pending(cfg_pending)
  );

  typedef struct { logic [PW-1:0] rgb; bit hs, vs, bl; } out_t;

  logic [N-1:0]  m_en_sh, m_en;
  logic [PW-1:0] m_bg_sh, m_bg;
  int            m_prio_sh [N];
  int            m_prio    [N];
  logic [PW-1:0] m_key_sh  [N];
  logic [PW-1:0] m_key     [N];
  bit            m_pend, m_commit_next, m_vs_prev;
  out_t          hist [$];
  logic [PW-1:0] e_rgb;
  bit            e_hs, e_vs, e_bl, e_fd, e_pend;
  int            n_vec = 0;
  int            n_err = 0;

  function automatic logic [28:0] dut_vec();
    return {rgb_out, hs_out, vs_out, blank_out, frame_drawn, cfg_pending};
  endfunction

  function automatic logic [28:0] exp_vec();
    return {e_rgb, e_hs, e_vs, e_bl, e_fd, e_pend};
  endfunction

  function automatic logic [PW-1:0] compose(input logic [N*PW-1:0] px);
    for (int s = 0; s < N; s++) begin
      int l;
      l = m_prio[s];
      if (l < N && m_en[l] && px[l*PW +: PW] != m_key[l]) return px[l*PW +: PW];
    end
    return m_bg;
  endfunction

  task automatic model_reset();
    out_t z;
    m_en_sh = '1; m_en = '1; m_bg_sh = '0; m_bg = '0;
    for (int s = 0; s < N; s++) begin
      m_prio_sh[s] = s; m_prio[s] = s; m_key_sh[s] = '0; m_key[s] = '0;
    end
    m_pend = 0; m_commit_next = 0; m_vs_prev = 0;
    z.rgb = '0; z.hs = 0; z.vs = 0; z.bl = 0;
    hist = {};
    hist.push_back(z);
    e_rgb = '0; e_hs = 0; e_vs = 0; e_bl = 0; e_fd = 0; e_pend = 0;
  endtask

  // One clock: the model consumes the same inputs the DUT samples on this edge.
  task automatic tick();
    out_t o;
    @(posedge clk);
    o.rgb = blank_in ? '0 : compose(layer_rgb);
    o.hs = hs_in; o.vs = vs_in; o.bl = blank_in;
    hist.push_back(o);
    if (m_commit_next) begin
      m_en = m_en_sh; m_bg = m_bg_sh; m_prio = m_prio_sh; m_key = m_key_sh; m_pend = 0;
    end
    if (cfg_we && cfg_addr < 4'(3 + N)) begin
      case (cfg_addr)
        4'd0: m_en_sh = cfg_data[N-1:0];
        4'd1: m_bg_sh = cfg_data[PW-1:0];
        4'd2: for (int s = 0; s < N; s++) m_prio_sh[s] = int'(cfg_data[s*4 +: 2]);
        default: m_key_sh[cfg_addr - 4'd3] = cfg_data[PW-1:0];
      endcase
      m_pend = 1;
    end
    m_commit_next = vs_in && !m_vs_prev;
    m_vs_prev = vs_in;
    o = hist.pop_front();
    e_fd = o.vs && !e_vs;
    e_rgb = o.rgb; e_hs = o.hs; e_vs = o.vs; e_bl = o.bl; e_pend = m_pend;
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_layers(input logic [PW-1:0] l0, l1, l2, l3);
    layer_rgb = {l3, l2, l1, l0};
  endtask

  task automatic vs_pulse();
    vs_in = 1'b1; tick();
    vs_in = 1'b0; tick();
    tick(); tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (dut_vec() !== 29'd0) begin
      n_err++; $display("FAIL reset_state: got %h want 0", dut_vec());
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (dut_vec() !== 29'd0 || exp_vec() !== 29'd0) begin
        n_err++; $display("FAIL reset_release c%0d: got %h want 0", i, dut_vec());
      end
    end
  endtask

  task automatic test_default();
    set_layers(24'h000000, 24'h123456, 24'h0A0B0C, 24'h0D0E0F);
    for (int i = 0; i < 4; i++) begin
      hs_in = i[0];
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL default c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    hs_in = 1'b0;
    n_vec++;
    if (rgb_out !== 24'h123456) begin
      n_err++; $display("FAIL default_rgb: got %h want 123456", rgb_out);
    end
  endtask

  task automatic test_priority();
    set_layers(24'h000000, 24'h123456, 24'h00FF00, 24'hFF0000);
    cfg_write(4'd2, 32'h0123);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec() || rgb_out !== 24'h123456 || cfg_pending !== 1'b1) begin
        n_err++; $display("FAIL prio_shadow c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    vs_in = 1'b1; tick();
    vs_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL prio_commit c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (rgb_out !== 24'hFF0000 || cfg_pending !== 1'b0) begin
      n_err++; $display("FAIL prio_active: got %h/%b want ff0000/0", rgb_out, cfg_pending);
    end
  endtask

  task automatic test_background();
    cfg_write(4'd0, 32'h0);
    cfg_write(4'd1, 32'h0000AA);
    vs_pulse();
    for (int i = 0; i < 5; i++) begin
      layer_rgb = {24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom)};
      blank_in = 1'b0;
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec() || rgb_out !== 24'h0000AA) begin
        n_err++; $display("FAIL background c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    blank_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec() || (i >= 1 && rgb_out !== 24'h0)) begin
        n_err++; $display("FAIL blank c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    blank_in = 1'b0;
  endtask

  task automatic test_commit_race();
    vs_in = 1'b1; tick();
    vs_in = 1'b0;
    cfg_write(4'd1, 32'h000055);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec() || rgb_out !== 24'h0000AA || cfg_pending !== 1'b1) begin
        n_err++; $display("FAIL race_hold c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    vs_pulse();
    tick();
    n_vec++;
    if (dut_vec() !== exp_vec() || rgb_out !== 24'h000055 || cfg_pending !== 1'b0) begin
      n_err++; $display("FAIL race_next: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_key();
    cfg_write(4'd0, 32'hF);
    cfg_write(4'd1, 32'h0);
    cfg_write(4'd2, 32'h3210);
    cfg_write(4'd3, 32'h0);
    cfg_write(4'd4, 32'h123456);
    cfg_write(4'd5, 32'h0);
    cfg_write(4'd6, 32'h0);
    vs_pulse();
    set_layers(24'h000000, 24'h123456, 24'hABCDEF, 24'h000000);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec() || (i == 2 && rgb_out !== 24'hABCDEF)) begin
        n_err++; $display("FAIL key_hidden c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    set_layers(24'h000000, 24'h123457, 24'hABCDEF, 24'h000000);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec() || (i == 2 && rgb_out !== 24'h123457)) begin
        n_err++; $display("FAIL key_shown c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_frame();
    int pulses;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      vs_in = (i >= 2 && i < 5);
      tick();
      if (frame_drawn === 1'b1) pulses++;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL frame c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++; $display("FAIL frame_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    cfg_write(4'd1, 32'h00BEEF);
    cfg_write(4'd0, 32'h0);
    vs_pulse();
    hs_in = 1'b1; blank_in = 1'b0;
    tick(); tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (dut_vec() !== 29'd0) begin
      n_err++; $display("FAIL reset_async: got %h want 0", dut_vec());
    end
    hs_in = 1'b0;
    vs_in = 1'b1;
    set_layers(24'h111111, 24'h222222, 24'h333333, 24'h444444);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) vs_in = 1'b0;
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL reset_mid c%0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (rgb_out !== 24'h111111 || cfg_pending !== 1'b0) begin
      n_err++; $display("FAIL reset_defaults: got %h/%b want 111111/0", rgb_out, cfg_pending);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        r = $urandom_range(0, 3);
        layer_rgb[i*PW +: PW] = (r == 0) ? m_key[i] : (r == 1) ? m_key_sh[i] : 24'($urandom);
      end
      hs_in    = 1'($urandom);
      blank_in = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) vs_in = ~vs_in;
      cfg_we   = ($urandom_range(0, 4) == 0);
      cfg_addr = 4'($urandom);
      cfg_data = $urandom;
      tick();
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++; $display("FAIL random c%0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    hs_in = 1'b0; vs_in = 1'b0; blank_in = 1'b0; layer_rgb = '0;
    test_reset();
    test_default();
    test_priority();
    test_background();
    test_commit_race();
    test_key();
    test_frame();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
